ssd_scan: RTL and testbench

SSD_SCAN -- requirements
Module: ssd_scan

---
 rtl/ssd_scan.sv | 145 ++++++++++++++
 tb/tb_ssd_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan.sv
// Multiplexed seven-segment scanner with a double-buffered display register.
// New data is committed only at a frame boundary, so a frame never shows mixed data.
module ssd_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int HEX_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an,
  output logic                upd
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]    BLANK    = 7'b1111111;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    g = BLANK;
    case (code)
      4'd0:  g = 7'b1000000;
      4'd1:  g = 7'b1111001;
      4'd2:  g = 7'b0100100;
      4'd3:  g = 7'b0110000;
      4'd4:  g = 7'b0011001;
      4'd5:  g = 7'b0010010;
      4'd6:  g = 7'b0000010;
      4'd7:  g = 7'b1111000;
      4'd8:  g = 7'b0000000;
      4'd9:  g = 7'b0010000;
      4'd10: g = 7'b0001000;
      4'd11: g = 7'b0000011;
      4'd12: g = 7'b1000110;
      4'd13: g = 7'b0100001;
      4'd14: g = 7'b0000110;
      4'd15: g = 7'b0001110;
    endcase
    if (code > 4'd9 && HEX_EN == 0)
      g = BLANK;
    return g;
  endfunction

  logic [CW-1:0]       cnt_p0;
  logic [IW-1:0]       idx_p0;
  logic [4*DIGITS-1:0] shadow, active;
  logic [DIGITS-1:0]   shadow_dp, active_dp;
  logic                pending;
  logic                tick, wrap, commit;

  assign tick   = en && (cnt_p0 == CNT_LAST);
  assign wrap   = tick && (idx_p0 == IDX_LAST);
  assign commit = wrap && pending;

  // Stage 0: prescaler and digit index; both hold while the display is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (en) begin
      cnt_p0 <= tick ? '0 : cnt_p0 + CW'(1);
      if (tick)
        idx_p0 <= wrap ? '0 : idx_p0 + IW'(1);
    end
  end

  // Shadow is always writable; active only changes on a frame wrap.
  // On a coincident load the commit sees the old shadow and pending stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      shadow_dp <= '0;
      active    <= '0;
      active_dp <= '0;
      pending   <= 1'b0;
      upd       <= 1'b0;
    end else begin
      upd <= commit;
      if (commit) begin
        active    <= shadow;
        active_dp <= shadow_dp;
      end
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp;
        pending   <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  logic [DIGITS-1:0] lz;
  logic              run;
  logic [3:0]        nib;
  logic              blanked;
  logic [6:0]        seg_p0;
  logic              dp_n_p0;
  logic [DIGITS-1:0] an_p0;

  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run   = run && (active[4*i +: 4] == 4'd0) && !active_dp[i];
      lz[i] = run;
    end
  end

  always_comb begin
    nib     = active[4*int'(idx_p0) +: 4];
    blanked = blank_lz && lz[idx_p0];
    seg_p0  = blanked ? BLANK : glyph(nib);
    dp_n_p0 = blanked ? 1'b1 : ~active_dp[idx_p0];
    an_p0   = '1;
    an_p0[idx_p0] = 1'b0;
  end

  // Stage 1: registered display drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg  <= BLANK;
      dp_n <= 1'b1;
      an   <= '1;
    end else if (en) begin
      seg  <= seg_p0;
      dp_n <= dp_n_p0;
      an   <= an_p0;
    end else begin
      seg  <= BLANK;
      dp_n <= 1'b1;
      an   <= '1;
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
// Randomized scoreboard bench for ssd_scan: a time-based reference model predicts
// every registered output; a monitor compares one clock later.
module tb_ssd_scan;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        upd;

  ssd_scan #(.DIGITS(DIGITS), .DIV(DIV), .HEX_EN(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp(dp),
    .blank_lz(blank_lz), .seg(seg), .dp_n(dp_n), .an(an), .upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp_n;
    logic [3:0] an;
    logic       upd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int upd_seen = 0;

  logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state: enabled-cycle phase within a frame plus the two data buffers
  int          m_ec = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic [3:0]  m_act_dp = '0, m_sh_dp = '0;
  bit          m_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_ec = 0;
    m_act = '0;
    m_sh = '0;
    m_act_dp = '0;
    m_sh_dp = '0;
    m_pend = 1'b0;
  endtask

  task automatic step(input logic e, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic bl);
    exp_t x;
    int   idx, msd;
    logic [3:0] nib;
    bit   blanked, commit;
    @(negedge clk);
    en = e; load = ld; value = v; dp = d; blank_lz = bl;
    idx = (m_ec / DIV) % DIGITS;
    msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (m_act[4*i +: 4] != 4'd0 || m_act_dp[i]) msd = i;
    blanked = bl && (idx > msd);
    nib = m_act[4*idx +: 4];
    commit = e && (m_ec % FRAME == FRAME - 1) && m_pend;
    if (e) begin
      x.seg  = blanked ? 7'h7f : gl[nib];
      x.dp_n = blanked ? 1'b1 : ~m_act_dp[idx];
      x.an   = ~(4'b0001 << idx);
    end else begin
      x.seg  = 7'h7f;
      x.dp_n = 1'b1;
      x.an   = 4'hf;
    end
    x.upd = commit;
    q.push_back(x);
    if (commit) begin
      m_act = m_sh;
      m_act_dp = m_sh_dp;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_sh = v;
      m_sh_dp = d;
      m_pend = 1'b1;
    end
    if (e) m_ec = (m_ec + 1) % FRAME;
  endtask

  task automatic idle(input int n, input logic bl);
    repeat (n) step(1'b1, 1'b0, 16'h0, 4'h0, bl);
  endtask

  task automatic align(input int k);
    while (m_ec % FRAME != k) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    exp_t x, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        got = {seg, dp_n, an, upd};
        if (upd) upd_seen++;
        total++;
        if (got !== x) begin
          bad++;
          $display("FAIL scan: got seg=%b dp_n=%b an=%b upd=%b want seg=%b dp_n=%b an=%b upd=%b",
                   got.seg, got.dp_n, got.an, got.upd, x.seg, x.dp_n, x.an, x.upd);
        end
      end
    end
  end

  initial begin
    int u0, n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'h7f);
    check("rst_dpn", 32'(dp_n), 32'h1);
    check("rst_an", 32'(an), 32'hf);
    check("rst_upd", 32'(upd), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic load and scan
    u0 = upd_seen;
    step(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    idle(40, 1'b0);
    check("upd_1234", 32'(upd_seen - u0), 32'd1);

    // Leading-zero blanking with hex glyphs, then blanking off
    align(2);
    u0 = upd_seen;
    step(1'b1, 1'b1, 16'h00AF, 4'h0, 1'b1);
    idle(40, 1'b1);
    idle(20, 1'b0);
    check("upd_00af", 32'(upd_seen - u0), 32'd1);

    // Two loads in one frame: last wins, one commit
    align(1);
    u0 = upd_seen;
    step(1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
    idle(40, 1'b0);
    check("upd_last_wins", 32'(upd_seen - u0), 32'd1);

    // Load coincident with the committing wrap tick
    align(2);
    u0 = upd_seen;
    step(1'b1, 1'b1, 16'h5555, 4'h3, 1'b0);
    while (m_ec % FRAME != FRAME - 1) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 16'h6789, 4'h0, 1'b0);
    idle(40, 1'b0);
    check("upd_coincident", 32'(upd_seen - u0), 32'd2);

    // Enable dropped mid-frame, with a load while disabled
    align(6);
    repeat (4) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0042, 4'h1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    idle(40, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        e, ld, bl;
      logic [15:0] v;
      logic [3:0]  d;
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 19) == 0);
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      d  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bl = (i / 100) % 2 == 1;
      step(e, ld, v, d, bl);
    end

    // Asynchronous reset with data pending
    align(1);
    step(1'b1, 1'b1, 16'hBEEF, 4'h0, 1'b0);
    idle(3, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_seg", 32'(seg), 32'h7f);
    check("arst_dpn", 32'(dp_n), 32'h1);
    check("arst_an", 32'(an), 32'hf);
    check("arst_upd", 32'(upd), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    load = 1'b0;
    u0 = upd_seen;
    idle(40, 1'b0);
    check("arst_no_upd", 32'(upd_seen - u0), 32'd0);

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
